// File: rtl/mul_seq_ctrl.sv
// Control and count stage for a repeated-addition multiplier: loads A, then B
// into a down-counter, then pulses the product load once per remaining count.
module mul_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   output logic             ldA,
   output logic             clrP,
   output logic             ldP,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LD_A = 3'd1,
      LD_B = 3'd2,
      ADD  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Kept as a plainly named register so checkers can bind to it directly.
   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // B down-counter: loaded in LD_B, decremented once per product load.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         case (state)
            LD_B:    cnt <= din;
            ADD:     cnt <= cnt - WIDTH'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Handshake: start is a level request sampled only in IDLE; it is neither
   // acknowledged nor queued elsewhere, and done is the single completion pulse.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LD_A;
         LD_A:    state_nxt = LD_B;
         LD_B:    state_nxt = (din == '0) ? DONE : ADD;
         ADD:     if (cnt <= WIDTH'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ldA  = 1'b0;
      clrP = 1'b0;
      ldP  = 1'b0;
      done = 1'b0;
      busy = (state != IDLE);
      case (state)
         LD_A:    ldA  = 1'b1;
         LD_B:    clrP = 1'b1;
         ADD:     ldP  = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: a 16-bit and a 4-bit instance, with a
// downstream A/P register model fed by the load enables.
module tb_mul_seq_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic        sel;       // 0: 16-bit instance, 1: 4-bit instance
   logic [15:0] din;

   logic        start16, start4;
   logic        lda16, clrp16, ldp16, busy16, done16;
   logic        lda4, clrp4, ldp4, busy4, done4;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;

   assign start16 = start & ~sel;
   assign start4  = start & sel;

   mul_seq_ctrl #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .din(din),
      .ldA(lda16), .clrP(clrp16), .ldP(ldp16), .busy(busy16), .done(done16),
      .cnt(cnt16)
   );

   mul_seq_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .din(din[3:0]),
      .ldA(lda4), .clrP(clrp4), .ldP(ldp4), .busy(busy4), .done(done4),
      .cnt(cnt4)
   );

   logic        m_lda, m_clrp, m_ldp, m_busy, m_done;
   logic [15:0] m_cnt;
   assign m_lda  = sel ? lda4  : lda16;
   assign m_clrp = sel ? clrp4 : clrp16;
   assign m_ldp  = sel ? ldp4  : ldp16;
   assign m_busy = sel ? busy4 : busy16;
   assign m_done = sel ? done4 : done16;
   assign m_cnt  = sel ? {12'd0, cnt4} : cnt16;

   // Downstream A and product registers driven by the controller enables.
   logic [15:0] a_reg;
   logic [31:0] p_reg;
   always @(posedge clk) begin
      if (m_lda) a_reg <= sel ? {12'd0, din[3:0]} : din;
      if (m_clrp)     p_reg <= '0;
      else if (m_ldp) p_reg <= p_reg + {16'd0, a_reg};
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Entered at a negedge with the DUT idle (or, with skip_start, at the
   // negedge of the LD_A cycle). Returns at the negedge of the IDLE cycle
   // following done.
   task automatic run_op(input bit skip_start, input logic [15:0] a,
                         input logic [15:0] b, input bit hold_start,
                         input string name);
      int idx, n_lda, n_clrp, n_ldp, n_busy, first_ldp, last_ldp, done_idx;
      n_lda = 0; n_clrp = 0; n_ldp = 0; n_busy = 0;
      first_ldp = 0; last_ldp = 0; done_idx = 0;
      exp_q.delete();
      for (int i = int'(b); i >= 1; i--) exp_q.push_back(16'(i));
      if (!skip_start) begin
         start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (!hold_start) start = 1'b0;
      end
      idx = 1;
      while (done_idx == 0 && idx <= int'(b) + 40) begin
         if (m_busy) n_busy++;
         if (m_lda)  begin n_lda++;  din = a; end
         if (m_clrp) begin n_clrp++; din = b; end
         if (m_ldp) begin
            n_ldp++;
            if (first_ldp == 0) first_ldp = idx;
            last_ldp = idx;
            if (exp_q.size() > 0) check({name, " cnt_add"}, 32'(m_cnt), 32'(exp_q.pop_front()));
         end
         if (m_done) begin
            done_idx = idx;
            check({name, " cnt_done"}, 32'(m_cnt), 32'd0);
         end else begin
            @(negedge clk);
            idx++;
         end
      end
      check({name, " done_latency"}, 32'(done_idx), 32'(b) + 32'd3);
      check({name, " ldA_pulses"}, 32'(n_lda), 32'd1);
      check({name, " clrP_pulses"}, 32'(n_clrp), 32'd1);
      check({name, " ldP_pulses"}, 32'(n_ldp), 32'(b));
      check({name, " busy_cycles"}, 32'(n_busy), 32'(b) + 32'd3);
      if (b != 0) begin
         check({name, " ldP_first"}, 32'(first_ldp), 32'd3);
         check({name, " ldP_last"}, 32'(last_ldp), 32'(b) + 32'd2);
      end
      check({name, " product"}, p_reg, 32'(a) * 32'(b));
      @(negedge clk);
      check({name, " idle_busy"}, 32'(m_busy), 32'd0);
      check({name, " idle_done"}, 32'(m_done), 32'd0);
      check({name, " idle_ldA"}, 32'(m_lda), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int dsum;
      rst = 1'b1; start = 1'b0; sel = 1'b0; din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset ldA",  32'(lda16),  32'd0);
      check("reset clrP", 32'(clrp16), 32'd0);
      check("reset ldP",  32'(ldp16),  32'd0);
      check("reset busy", 32'(busy16), 32'd0);
      check("reset done", 32'(done16), 32'd0);
      check("reset cnt",  32'(cnt16),  32'd0);
      check("reset cnt4", 32'(cnt4),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: nominal 17 x 5
      run_op(1'b0, 16'd17, 16'd5, 1'b0, "t1");
      // 2: B = 0
      run_op(1'b0, 16'd9, 16'd0, 1'b0, "t2");

      // 3: 4-bit instance, B = 1 and maximum B = 15
      sel = 1'b1;
      @(negedge clk);
      run_op(1'b0, 16'd7, 16'd1, 1'b0, "t3 b1");
      run_op(1'b0, 16'd3, 16'd15, 1'b0, "t3 b15");
      sel = 1'b0;
      @(negedge clk);

      // 4: start held high through a whole operation
      run_op(1'b0, 16'd3, 16'd2, 1'b1, "t4a");
      @(negedge clk);
      check("t4 restart_from_idle", 32'(m_lda), 32'd1);
      start = 1'b0;
      run_op(1'b1, 16'd3, 16'd2, 1'b0, "t4b");

      // 5: reset during the third ADD cycle
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (m_lda)  din = 16'd4;
         if (m_clrp) din = 16'd10;
         if (i < 5) @(negedge clk);
      end
      check("t5 third_add_ldP", 32'(m_ldp), 32'd1);
      check("t5 third_add_cnt", 32'(m_cnt), 32'd8);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t5 rst ldA",  32'(m_lda),  32'd0);
      check("t5 rst clrP", 32'(m_clrp), 32'd0);
      check("t5 rst ldP",  32'(m_ldp),  32'd0);
      check("t5 rst busy", 32'(m_busy), 32'd0);
      check("t5 rst done", 32'(m_done), 32'd0);
      check("t5 rst cnt",  32'(m_cnt),  32'd0);
      rst = 1'b0;
      dsum = 0;
      repeat (3) begin
         @(negedge clk);
         dsum += int'(m_done) + int'(m_busy);
      end
      check("t5 quiet_after_rst", 32'(dsum), 32'd0);
      run_op(1'b0, 16'd4, 16'd10, 1'b0, "t5 rerun");

      // 6: back-to-back, second start in the first IDLE cycle
      run_op(1'b0, 16'd2, 16'd3, 1'b0, "t6a");
      run_op(1'b0, 16'd6, 16'd7, 1'b0, "t6b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Control and count stage for the repeated-addition 16-bit multiplier.
- Drives the load enables of the operand-A and product parallel-in/parallel-out registers. Owns the multiplier (B) down-counter and its zero detect.
- Captures operands A then B from a shared din bus on consecutive cycles, then pulses the product load once per remaining count. Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 16, width of din bus and of B down-counter.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply. Sampled only in IDLE.
- din  input  WIDTH  shared operand bus. Carries A during the LD_A cycle and B during the LD_B cycle.
- ldA  output  1  load enable to A register. A register captures din at the end of the cycle.
- clrP  output  1  synchronous clear to product register.
- ldP  output  1  load enable to product register, which captures A+P.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- cnt  output  WIDTH  current B down-counter value, for debug/verification.

Behaviour:
- Reset: synchronous, active-high. On the first rising clk edge with rst=1:
  - state goes to IDLE and cnt goes to 0.
  - ldA, clrP, ldP, busy and done are all 0.
  - rst has priority over every other input, in any state, including mid-ADD.
- Outputs are Moore outputs, decoded only from the registered state. There is no combinational path from start or din to any output.
- States: IDLE, LD_A, LD_B, ADD, DONE.
- IDLE:
  - All outputs 0.
  - start=1 at an edge moves to LD_A; otherwise remain in IDLE.
- LD_A:
  - ldA=1 and busy=1.
  - Next state is LD_B unconditionally.
- LD_B:
  - clrP=1 and busy=1.
  - cnt <= din at the edge.
  - If din==0, next state is DONE; else next state is ADD.
- ADD:
  - ldP=1 and busy=1.
  - cnt <= cnt-1 at each edge.
  - If cnt==1 at the edge, next state is DONE; else remain in ADD.
  - cnt never wraps: ADD is never entered or held with cnt==0.
- DONE:
  - done=1 and busy=1.
  - Next state is IDLE unconditionally.
  - start is ignored in this state; a new request needs start asserted in IDLE.
- start asserted in any state other than IDLE has no effect and is not queued.
- Pulse counts per operation:
  - Exactly one ldA pulse and exactly one clrP pulse.
  - Exactly B ldP pulses, back-to-back.
  - Exactly one done pulse.
- Latency, with start sampled at edge k:
  - LD_A is the cycle after k; LD_B is the next cycle.
  - ADD occupies B cycles; done is high (B+3) cycles after k.
  - If B==0, done is high 3 cycles after k.
- Total occupancy is B+4 cycles from IDLE back to IDLE.
- Width rule: cnt is an unsigned WIDTH-bit value. The maximum B is 2^WIDTH-1, giving that many ADD cycles.
- The product register width and overflow are outside this block.

Test Plan:
1. Nominal multiply: reset, start=1 for one cycle, din=17 in LD_A, din=5 in LD_B.
   Required: ldA 1 cycle, clrP 1 cycle, ldP 5 consecutive cycles, cnt sequence 5,4,3,2,1,0, done 8 cycles after start edge. Downstream product register reads 85.
2. B=0: start, A=9, B=0.
   Required: no ldP pulses, clrP once, done 3 cycles after start, cnt=0. Product is 0.
3. B=1 and maximum B with WIDTH=4: B=1 gives a single ldP and done at start+4. B=15 gives 15 ldP pulses and done at start+18, with no cnt wrap.
4. Start while busy: assert start continuously from IDLE through DONE with A=3, B=2.
   Required: one operation completes (done at start+5). IDLE is held for at least one cycle, then a second operation begins only from IDLE.
5. Reset mid-operation: A=4, B=10, assert rst during the third ADD cycle.
   Required at the next edge: all outputs 0, cnt=0, busy=0, no done pulse. A subsequent start runs a full clean operation.
6. Back-to-back: start re-asserted on the first IDLE cycle after done, A=2, B=3 then A=6, B=7.
   Required: two independent operations of 7 and 11 cycles. Products read 6 and 42.
